// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder: one full-adder cell stepped once per clock, LSB first

module FullAdder (
    input  logic A,
    input  logic B,
    input  logic X,
    output logic S,
    output logic C
);
    assign S = A ^ B ^ X;
    assign C = (A & B) | (X & (A ^ B));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             COUT
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_s;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_sum_next;

    FullAdder u_fa (
        .A (r_sa[0]),
        .B (r_sb[0]),
        .X (r_carry),
        .S (w_s),
        .C (w_c)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_next = w_s;
        end else begin : g_sum_wn
            assign w_sum_next = {w_s, r_sum[WIDTH-1:1]};
        end
    endgenerate

    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_accept = START && ((r_state == ST_IDLE) || (r_state == ST_FIN));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (START) w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_FIN;
            ST_FIN:  w_state_next = START ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_sum   <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_RUN);
            r_done  <= (w_state_next == ST_FIN);
            if (w_accept) begin
                r_sa    <= A;
                r_sb    <= B;
                r_carry <= CIN;
                r_cnt   <= '0;
            end else if (r_state == ST_RUN) begin
                r_sa    <= r_sa >> 1;
                r_sb    <= r_sb >> 1;
                r_sum   <= w_sum_next;
                r_carry <= w_c;
                r_cnt   <= r_cnt + CW'(1);
                // Results are published only on the final bit so S never shows partial sums.
                if (w_last) begin
                    r_s    <= w_sum_next;
                    r_cout <= w_c;
                end
            end
        end
    end

    assign BUSY = r_busy;
    assign DONE = r_done;
    assign S    = r_s;
    assign COUT = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=1)

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic       cin8;
    logic       a1, b1, cin1;
    logic       busy8, done8, cout8;
    logic [7:0] s8;
    logic       busy1, done1, cout1;
    logic [0:0] s1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .CLK(clk), .RST(rst), .START(start8), .A(a8), .B(b8), .CIN(cin8),
        .BUSY(busy8), .DONE(done8), .S(s8), .COUT(cout8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .CLK(clk), .RST(rst), .START(start1), .A(a1), .B(b1), .CIN(cin1),
        .BUSY(busy1), .DONE(done1), .S(s1), .COUT(cout1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, then follow it until DONE (bounded) recording latency and BUSY cycles.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output int lat, output int busy_cnt, output int overlap);
        a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        tick();
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        lat = 0; busy_cnt = 0; overlap = 0;
        while (!done8 && lat < 40) begin
            if (busy8) busy_cnt++;
            tick();
            lat++;
        end
        if (busy8 && done8) overlap++;
    endtask

    task automatic count_done8(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done8) n++;
        end
    endtask

    int lat, busy_cnt, overlap, ndone, t_first;
    logic [1:0] fa_exp;

    initial begin
        rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        tick(); tick();
        check("reset_busy", busy8, 0);
        check("reset_done", done8, 0);
        check("reset_s", s8, 0);
        check("reset_cout", cout8, 0);
        check("reset_w1_s", {cout1, s1}, 0);
        rst = 1'b0;
        tick();

        run8(8'h5A, 8'h3C, 1'b0, lat, busy_cnt, overlap);
        check("5a3c_latency", lat, 8);
        check("5a3c_busy_cycles", busy_cnt, 8);
        check("5a3c_no_overlap", overlap, 0);
        check("5a3c_s", s8, 8'h96);
        check("5a3c_cout", cout8, 0);
        tick();
        check("5a3c_done_pulse", done8, 0);

        run8(8'hFF, 8'h01, 1'b0, lat, busy_cnt, overlap);
        check("ff01_s", s8, 8'h00);
        check("ff01_cout", cout8, 1);
        tick();
        run8(8'hFF, 8'hFF, 1'b1, lat, busy_cnt, overlap);
        check("ffff1_s", s8, 8'hFF);
        check("ffff1_cout", cout8, 1);
        tick();

        // START with different operands during RUN must be dropped.
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        check("run_s_held", s8, 8'hFF);
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        tick();
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        lat = 3;
        while (!done8 && lat < 40) begin tick(); lat++; end
        check("ignore_latency", lat, 8);
        check("ignore_s", s8, 8'h46);
        check("ignore_cout", cout8, 0);
        count_done8(12, ndone);
        check("ignore_single_done", ndone, 0);

        // START held high: second op is accepted in the FIN cycle.
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick();
        lat = 0;
        while (!done8 && lat < 40) begin tick(); lat++; end
        t_first = lat;
        check("b2b_first_latency", t_first, 8);
        check("b2b_first_s", {cout8, s8}, 9'h002);
        a8 = 8'h80; b8 = 8'h80;
        tick();
        start8 = 1'b0;
        check("b2b_busy_after_fin", busy8, 1);
        lat = 1;
        while (!done8 && lat < 40) begin tick(); lat++; end
        check("b2b_done_spacing", lat, 9);
        check("b2b_second_s", s8, 8'h00);
        check("b2b_second_cout", cout8, 1);
        tick();

        // Reset in the middle of a run aborts it silently.
        run8(8'h5A, 8'h3C, 1'b0, lat, busy_cnt, overlap);
        check("pre_abort_s", s8, 8'h96);
        tick();
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_s", s8, 0);
        check("abort_cout", cout8, 0);
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        count_done8(12, ndone);
        check("abort_no_done", ndone, 0);
        run8(8'h01, 8'h02, 1'b0, lat, busy_cnt, overlap);
        check("post_abort_s", s8, 8'h03);
        check("post_abort_latency", lat, 8);

        // WIDTH=1: full-adder truth table, DONE one edge after accept.
        for (int v = 0; v < 8; v++) begin
            a1 = v[2]; b1 = v[1]; cin1 = v[0];
            fa_exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            check($sformatf("w1_busy_%0d", v), busy1, 1);
            tick();
            check($sformatf("w1_done_%0d", v), done1, 1);
            check($sformatf("w1_sum_%0d", v), {cout1, s1}, fa_exp);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
